// File: rtl/dco_sdm_pkg.sv
// dco_sdm_pkg
//   Shared constants for the MASH 1-1 DCO sigma-delta modulator:
//   word-split widths, integer-code offset, dither LFSR seed/taps and
//   the legal range of the dither output.
package dco_sdm_pkg;

  localparam int FRAC_W         = 6;
  localparam int NC_W           = 15;
  localparam int DCO_INT_OFFSET = 512;

  // x^15 + x^14 + 1, shifting towards the MSB, feedback into bit 0
  localparam logic [14:0] LFSR_SEED  = 15'h0001;
  localparam int          LFSR_TAP_A = 14;
  localparam int          LFSR_TAP_B = 13;

  localparam int Y_MIN = -1;
  localparam int Y_MAX = 2;

endpackage

// File: rtl/sdm_acc_stage.sv
// sdm_acc_stage
//   W-bit modulo accumulator with carry-out. The sum and carry are
//   combinational from the current accumulator and addend; the
//   accumulator takes the low W bits of the sum on each enabled edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en_i       : advance the accumulator
//   clr_i      : synchronous clear (wins over en_i)
//   add_i      : addend
//   cin_i      : extra LSB addend (dither bit)
//   sum_o      : low W bits of acc + add_i + cin_i
//   carry_o    : overflow carry of that sum
module sdm_acc_stage
  import dco_sdm_pkg::*;
#(
  parameter int W = FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] add_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W-1:0] acc_q;
  logic [W:0]   sum_full;

  assign sum_full = {1'b0, acc_q} + {1'b0, add_i} + {{W{1'b0}}, cin_i};
  assign sum_o    = sum_full[W-1:0];
  assign carry_o  = sum_full[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_full[W-1:0];
    end
  end

endmodule

// File: rtl/dco_sdm.sv
// dco_sdm
//   Second-order MASH 1-1 sigma-delta modulator feeding the DCO banks.
//   Splits the loop-filter word into an offset-binary integer code and
//   a dithered fractional correction, and integrates the quantization
//   error for the loop filter's noise cancellation.
// Ports:
//   clk      : filter-rate clock
//   rstn     : async active-low reset
//   enable   : modulator enable (synchronous to clk)
//   din      : signed word, [15:FRAC_W] integer, [FRAC_W-1:0] fraction
//   dco_int  : integer code, din integer part + 512 (modulo 1024)
//   dco_dith : signed fractional correction, -1..+2
//   nc_out   : saturated integrated quantization error
// Build option:
//   DCO_SDM_DITHER_EN : adds a 15-bit LFSR bit into the first accumulator.
module dco_sdm #(
  parameter int FRAC_W = dco_sdm_pkg::FRAC_W,
  parameter int NC_W   = dco_sdm_pkg::NC_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic [15:0]        din,
  output logic [15-FRAC_W:0] dco_int,
  output logic [2:0]         dco_dith,
  output logic [NC_W-1:0]    nc_out
);
  import dco_sdm_pkg::*;

  localparam int IP_W = 16 - FRAC_W;
  localparam int NC_HI_I = (1 << (NC_W - 1)) - 1;
  localparam logic signed [15:0] NC_HI = NC_HI_I[15:0];
  localparam logic signed [15:0] NC_LO = ~NC_HI;

  logic [15:0]       din_r_q;
  logic [FRAC_W-1:0] frac;
  logic [IP_W-1:0]   ip;
  logic [FRAC_W-1:0] s1_lo;
  logic [FRAC_W-1:0] s2_lo;
  logic              c1, c2;
  logic              dith_bit;

  logic              c1_q, c2_q, c2_d_q;
  logic [IP_W-1:0]   ip_d_q;
  logic [FRAC_W-1:0] frac_d_q;
  logic [2:0]        dith_q;
  logic [IP_W-1:0]   int_q;
  logic [15:0]       ph_q;

  logic [2:0]        y;
  logic [15:0]       y_ext;
  logic [15:0]       ph_d;
  logic [IP_W-1:0]   int_d;

  assign frac = din_r_q[FRAC_W-1:0];
  assign ip   = din_r_q[15:FRAC_W];

`ifdef DCO_SDM_DITHER_EN
  logic [14:0] lfsr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else if (!enable) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[13:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
    end
  end

  assign dith_bit = lfsr_q[0];
`else
  assign dith_bit = 1'b0;
`endif

  sdm_acc_stage #(.W(FRAC_W)) u_acc1 (
    .clk     (clk),
    .rst_n   (rstn),
    .en_i    (enable),
    .clr_i   (~enable),
    .add_i   (frac),
    .cin_i   (dith_bit),
    .sum_o   (s1_lo),
    .carry_o (c1)
  );

  sdm_acc_stage #(.W(FRAC_W)) u_acc2 (
    .clk     (clk),
    .rst_n   (rstn),
    .en_i    (enable),
    .clr_i   (~enable),
    .add_i   (s1_lo),
    .cin_i   (1'b0),
    .sum_o   (s2_lo),
    .carry_o (c2)
  );

  // MASH 1-1 combiner: c1 + c2 - c2 of the previous sample, modulo 8
  assign y     = {2'b00, c1_q} + {2'b00, c2_q} - {2'b00, c2_d_q};
  assign y_ext = {{13{y[2]}}, y} << FRAC_W;
  assign ph_d  = ph_q + y_ext - {{(16-FRAC_W){1'b0}}, frac_d_q};
  assign int_d = ip_d_q + IP_W'(DCO_INT_OFFSET);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_r_q <= '0;
    end else if (enable) begin
      din_r_q <= din;
    end
  end

  // frac_d clears with the carries so ph restarts aligned with y
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      ip_d_q   <= '0;
      frac_d_q <= '0;
    end else if (enable) begin
      c1_q     <= c1;
      c2_q     <= c2;
      ip_d_q   <= ip;
      frac_d_q <= frac;
    end else begin
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      frac_d_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c2_d_q <= 1'b0;
      dith_q <= '0;
      int_q  <= IP_W'(DCO_INT_OFFSET);
      ph_q   <= '0;
    end else if (enable) begin
      c2_d_q <= c2_q;
      dith_q <= y;
      int_q  <= int_d;
      ph_q   <= ph_d;
    end else begin
      c2_d_q <= 1'b0;
      dith_q <= '0;
      ph_q   <= '0;
    end
  end

  // ph wraps freely; only the exported view saturates
  always_comb begin
    nc_out = ph_q[NC_W-1:0];
    if ($signed(ph_q) > NC_HI) begin
      nc_out = NC_HI[NC_W-1:0];
    end else if ($signed(ph_q) < NC_LO) begin
      nc_out = NC_LO[NC_W-1:0];
    end
  end

  assign dco_int  = int_q;
  assign dco_dith = dith_q;

endmodule

// File: tb/tb_dco_sdm.sv
// tb_dco_sdm
//   Directed checks of dco_sdm: reset, zero fraction, half LSB,
//   integer extremes, enable drop / re-enable, async reset, and the
//   dither build when DCO_SDM_DITHER_EN is defined.
module tb_dco_sdm;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] din;
  logic [9:0]  dco_int;
  logic [2:0]  dco_dith;
  logic [14:0] nc_out;

  int n_cmp = 0;
  int n_err = 0;

  // hand-derived MASH output for frac=21 from cleared state, and ph after each
  int y_tab[7]   = '{0, 0, 1, 1, -1, 1, 1};
  int nc_tab[7]  = '{-21, -42, 1, 44, -41, 2, 45};
  // frac=32: y period 0,1,1,0; ph -32,0,32,0
  int half_y[4]  = '{0, 1, 1, 0};
  int half_nc[4] = '{-32, 0, 32, 0};

  always #5 clk = ~clk;

  dco_sdm dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .din      (din),
    .dco_int  (dco_int),
    .dco_dith (dco_dith),
    .nc_out   (nc_out)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    int bad;
    int d;
    int v;

    rstn   = 1'b0;
    enable = 1'b0;
    din    = 16'h0000;
    #23;
    chk("rst_int", int'(dco_int), 512);
    chk("rst_dith", int'($signed(dco_dith)), 0);
    chk("rst_nc", int'($signed(nc_out)), 0);
    #5 rstn = 1'b1;
    step();
    step();
    chk("idle_int", int'(dco_int), 512);
    chk("idle_dith", int'($signed(dco_dith)), 0);
    chk("idle_nc", int'($signed(nc_out)), 0);

    // zero fraction
    din    = 16'h0040;
    enable = 1'b1;
    step();
    step();
    chk("zero_int_pre", int'(dco_int), 512);
    step();
    chk("zero_int", int'(dco_int), 513);
    for (int i = 0; i < 10; i++) begin
      step();
`ifndef DCO_SDM_DITHER_EN
      chk("zero_dith", int'($signed(dco_dith)), 0);
      chk("zero_nc", int'($signed(nc_out)), 0);
`endif
    end

    // integer extremes
    din = 16'h8000;
    repeat (3) step();
    chk("min_int", int'(dco_int), 0);
`ifndef DCO_SDM_DITHER_EN
    chk("min_dith", int'($signed(dco_dith)), 0);
`endif
    din = 16'h7FC0;
    repeat (3) step();
    chk("max_int", int'(dco_int), 1023);
`ifndef DCO_SDM_DITHER_EN
    chk("max_dith", int'($signed(dco_dith)), 0);
`endif

    // half LSB
    din = 16'h0020;
    step();
    step();
    sum = 0;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      d = int'($signed(dco_dith));
      v = int'($signed(nc_out));
      sum += d;
      if (d < -1 || d > 2 || v > 128 || v < -128) bad++;
`ifndef DCO_SDM_DITHER_EN
      if (i < 4) begin
        chk("half_y", d, half_y[i]);
        chk("half_nc", v, half_nc[i]);
      end
`endif
    end
    chk("half_range", bad, 0);
`ifndef DCO_SDM_DITHER_EN
    chk("half_sum", sum, 64);
`endif

    // enable drop mid-run
    rstn = 1'b0;
    #2 rstn = 1'b1;
    din    = 16'h0015;
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
`ifndef DCO_SDM_DITHER_EN
      if (k >= 3 && k <= 9) begin
        chk("run_y", int'($signed(dco_dith)), y_tab[k-3]);
        chk("run_nc", int'($signed(nc_out)), nc_tab[k-3]);
      end
`endif
    end
    enable = 1'b0;
    din    = 16'h0080;
    step();
    chk("drop_dith", int'($signed(dco_dith)), 0);
    chk("drop_nc", int'($signed(nc_out)), 0);
    chk("drop_int", int'(dco_int), 512);
    step();
    din    = 16'h0015;
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) chk("reen_int", int'(dco_int), 512);
`ifndef DCO_SDM_DITHER_EN
      if (k >= 2) begin
        chk("reen_y", int'($signed(dco_dith)), y_tab[k-2]);
        chk("reen_nc", int'($signed(nc_out)), nc_tab[k-2]);
      end
`endif
    end

    // async reset mid-run
    din = 16'h003F;
    repeat (10) step();
    #3 rstn = 1'b0;
    #1;
    chk("arst_int", int'(dco_int), 512);
    chk("arst_dith", int'($signed(dco_dith)), 0);
    chk("arst_nc", int'($signed(nc_out)), 0);
    #2 rstn = 1'b1;
    step();

`ifdef DCO_SDM_DITHER_EN
    begin
      logic [14:0] lfsr;
      int ones;
      int nz;
      int err;
      rstn = 1'b0;
      #2 rstn = 1'b1;
      din    = 16'h0000;
      enable = 1'b1;
      lfsr = 15'h0001;
      ones = 0;
      nz   = 0;
      sum  = 0;
      for (int k = 0; k < 1000; k++) begin
        ones += int'(lfsr[0]);
        lfsr = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        step();
        d = int'($signed(dco_dith));
        sum += d;
        if (d != 0) nz++;
      end
      err = sum * 64 - ones;
      if (err < 0) err = -err;
      chk("dith_active", int'(nz > 0), 1);
      chk("dith_sum", int'(err <= 128), 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
